// File: rtl/lru_cache_ctrl.sv
// Lookup/replacement controller for a 4-way set-associative cache.
// Holds per-set tags, valid bits and a 6-bit pairwise LRU state. It accepts one
// lookup at a time and resolves it as a hit or a miss. On a miss it picks a
// victim way, runs the line fill through a memory handshake, and then updates
// the LRU state. The data RAM is external and indexed by {set, way}.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   req_valid/req_ready      CPU lookup handshake; req_addr = {tag, set}
//   resp_valid/hit/way       one-cycle response strobe with hit flag and way
//   mem_req_valid/ready      fill request handshake; mem_req_addr/way = target
//   mem_fill_done            one-cycle pulse: the fill data has been written
//   flush/flush_busy         invalidate-all request (IDLE only) and sweep status
module lru_cache_ctrl #(
  parameter int  SET_BITS = 4,
  parameter int  TAG_BITS = 8,
  localparam int ADDR_W   = TAG_BITS + SET_BITS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [1:0]        resp_way,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [1:0]        mem_req_way,
  input  logic              mem_fill_done,
  input  logic              flush,
  output logic              flush_busy
);

  localparam int NSETS = 1 << SET_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_FILL_REQ, S_FILL_WAIT, S_RESP, S_FLUSH
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [1:0]            way_q, way_d;
  logic                  hit_q, hit_d;
  logic [SET_BITS-1:0]   flush_cnt_q, flush_cnt_d;
  logic [TAG_BITS-1:0]   tag_q [NSETS][4];
  logic [TAG_BITS-1:0]   tag_d [NSETS][4];
  logic [3:0]            valid_q [NSETS];
  logic [3:0]            valid_d [NSETS];
  logic [5:0]            lru_q [NSETS];
  logic [5:0]            lru_d [NSETS];

  logic [SET_BITS-1:0]   set_idx;
  logic [TAG_BITS-1:0]   tag_cur;
  logic                  hit_any, inv_any;
  logic [1:0]            hit_way, inv_way;

  // Mark a way most-recently-used in the pairwise LRU state.
  function automatic logic [5:0] lru_touch(input logic [5:0] lru, input logic [1:0] way);
    logic [5:0] r;
    case (way)
      2'd0:    r = lru | 6'b111000;
      2'd1:    r = (lru & 6'b011111) | 6'b000110;
      2'd2:    r = (lru & 6'b101011) | 6'b000001;
      default: r = lru & 6'b110100;
    endcase
    return r;
  endfunction

  // Least-recently-used way; first matching pattern wins, fallback way 0.
  function automatic logic [1:0] lru_victim(input logic [5:0] lru);
    logic [1:0] r;
    if (lru[5:3] == 3'b000)                          r = 2'd0;
    else if (lru[5] && lru[2:1] == 2'b00)            r = 2'd1;
    else if (lru[4] && lru[2] && !lru[0])            r = 2'd2;
    else if (lru[3] && lru[1:0] == 2'b11)            r = 2'd3;
    else                                             r = 2'd0;
    return r;
  endfunction

  assign set_idx = addr_q[SET_BITS-1:0];
  assign tag_cur = addr_q[ADDR_W-1:SET_BITS];

  // Downward scan so the lowest-index match / invalid way wins.
  always_comb begin
    hit_any = 1'b0;
    hit_way = 2'd0;
    inv_any = 1'b0;
    inv_way = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (valid_q[set_idx][w] && tag_q[set_idx][w] == tag_cur) begin
        hit_any = 1'b1;
        hit_way = 2'(w);
      end
      if (!valid_q[set_idx][w]) begin
        inv_any = 1'b1;
        inv_way = 2'(w);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    way_d       = way_q;
    hit_d       = hit_q;
    flush_cnt_d = flush_cnt_q;
    tag_d       = tag_q;
    valid_d     = valid_q;
    lru_d       = lru_q;
    case (state_q)
      S_IDLE: begin
        if (flush) begin
          flush_cnt_d = '0;
          state_d     = S_FLUSH;
        end else if (req_valid) begin
          addr_d  = req_addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any) begin
          lru_d[set_idx] = lru_touch(lru_q[set_idx], hit_way);
          way_d          = hit_way;
          hit_d          = 1'b1;
          state_d        = S_RESP;
        end else begin
          way_d   = inv_any ? inv_way : lru_victim(lru_q[set_idx]);
          hit_d   = 1'b0;
          state_d = S_FILL_REQ;
        end
      end
      S_FILL_REQ: begin
        if (mem_req_ready) state_d = S_FILL_WAIT;
      end
      S_FILL_WAIT: begin
        if (mem_fill_done) begin
          tag_d[set_idx][way_q]   = tag_cur;
          valid_d[set_idx][way_q] = 1'b1;
          lru_d[set_idx]          = lru_touch(lru_q[set_idx], way_q);
          state_d                 = S_RESP;
        end
      end
      S_RESP: state_d = S_IDLE;
      S_FLUSH: begin
        valid_d[flush_cnt_q] = 4'b0000;
        lru_d[flush_cnt_q]   = 6'b000000;
        flush_cnt_d          = flush_cnt_q + 1'b1;
        if (flush_cnt_q == SET_BITS'(NSETS - 1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      way_q       <= 2'd0;
      hit_q       <= 1'b0;
      flush_cnt_q <= '0;
      for (int s = 0; s < NSETS; s++) begin
        valid_q[s] <= 4'b0000;
        lru_q[s]   <= 6'b000000;
        for (int w = 0; w < 4; w++) tag_q[s][w] <= '0;
      end
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      way_q       <= way_d;
      hit_q       <= hit_d;
      flush_cnt_q <= flush_cnt_d;
      tag_q       <= tag_d;
      valid_q     <= valid_d;
      lru_q       <= lru_d;
    end
  end

  // All outputs come from state or registers only.
  assign req_ready     = (state_q == S_IDLE);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_hit      = hit_q;
  assign resp_way      = way_q;
  assign mem_req_valid = (state_q == S_FILL_REQ);
  assign mem_req_addr  = addr_q;
  assign mem_req_way   = way_q;
  assign flush_busy    = (state_q == S_FLUSH);

endmodule

// File: tb/tb_lru_cache_ctrl.sv
module tb_lru_cache_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [11:0] req_addr;
  logic        resp_valid, resp_hit;
  logic [1:0]  resp_way;
  logic        mem_req_valid, mem_req_ready;
  logic [11:0] mem_req_addr;
  logic [1:0]  mem_req_way;
  logic        mem_fill_done, flush, flush_busy;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q [$];

  always #5 clk = ~clk;

  lru_cache_ctrl #(.SET_BITS(4), .TAG_BITS(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_req_way(mem_req_way),
    .mem_fill_done(mem_fill_done), .flush(flush), .flush_busy(flush_busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: every strobe must match the oldest expected response.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        chk("resp_hit_way", {29'd0, resp_hit, resp_way}, {29'd0, e});
      end
    end
  end

  typedef struct {
    logic [7:0] tag;
    logic [3:0] set;
    logic       hit;
    logic [1:0] way;
    int         dly;
    logic [5:0] lru;
  } vec_t;

  task automatic do_req(input vec_t v);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_addr  = {v.tag, v.set};
    exp_q.push_back({v.hit, v.way});
    @(negedge clk);
    req_valid = 1'b0;
    chk("accepted", {31'd0, req_ready}, 32'd0);
    if (v.hit) begin
      chk("hit_early_resp", {31'd0, resp_valid}, 32'd0);
      @(negedge clk);
      chk("hit_latency", {31'd0, resp_valid}, 32'd1);
      chk("hit_no_memreq", {31'd0, mem_req_valid}, 32'd0);
    end else begin
      @(negedge clk);
      chk("memreq_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("memreq_addr", {20'd0, mem_req_addr}, {20'd0, v.tag, v.set});
      chk("memreq_way", {30'd0, mem_req_way}, {30'd0, v.way});
      for (int i = 0; i < v.dly; i++) begin
        mem_fill_done = (i == 1);
        @(negedge clk);
        mem_fill_done = 1'b0;
        chk("stall_valid", {31'd0, mem_req_valid}, 32'd1);
        chk("stall_addr_way", {18'd0, mem_req_addr, mem_req_way}, {18'd0, v.tag, v.set, v.way});
        chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
      end
      mem_req_ready = 1'b1;
      @(negedge clk);
      mem_req_ready = 1'b0;
      chk("memreq_dropped", {31'd0, mem_req_valid}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk("no_resp_before_fill", {31'd0, resp_valid}, 32'd0);
      mem_fill_done = 1'b1;
      @(negedge clk);
      mem_fill_done = 1'b0;
      chk("miss_latency", {31'd0, resp_valid}, 32'd1);
    end
    @(negedge clk);
    chk("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    chk("lru_state", {26'd0, dut.lru_q[v.set]}, {26'd0, v.lru});
  endtask

  vec_t vecs [20];

  initial begin
    vecs[0]  = '{8'h12, 4'd3, 1'b0, 2'd0, 0, 6'b111000};
    vecs[1]  = '{8'h13, 4'd3, 1'b0, 2'd1, 0, 6'b011110};
    vecs[2]  = '{8'h14, 4'd3, 1'b0, 2'd2, 5, 6'b001011};
    vecs[3]  = '{8'h15, 4'd3, 1'b0, 2'd3, 0, 6'b000000};
    vecs[4]  = '{8'h12, 4'd3, 1'b1, 2'd0, 0, 6'b111000};
    vecs[5]  = '{8'h16, 4'd3, 1'b0, 2'd1, 0, 6'b011110};
    vecs[6]  = '{8'h14, 4'd3, 1'b1, 2'd2, 0, 6'b001011};
    vecs[7]  = '{8'h16, 4'd3, 1'b1, 2'd1, 0, 6'b001111};
    vecs[8]  = '{8'h20, 4'd5, 1'b0, 2'd0, 0, 6'b111000};
    vecs[9]  = '{8'h21, 4'd5, 1'b0, 2'd1, 3, 6'b011110};
    vecs[10] = '{8'h22, 4'd5, 1'b0, 2'd2, 0, 6'b001011};
    vecs[11] = '{8'h23, 4'd5, 1'b0, 2'd3, 0, 6'b000000};
    vecs[12] = '{8'h24, 4'd5, 1'b0, 2'd0, 0, 6'b111000};
    vecs[13] = '{8'h15, 4'd3, 1'b1, 2'd3, 0, 6'b000100};
    vecs[14] = '{8'h20, 4'd5, 1'b0, 2'd1, 0, 6'b011110};
    vecs[15] = '{8'h13, 4'd3, 1'b0, 2'd0, 0, 6'b111100};
    vecs[16] = '{8'h17, 4'd3, 1'b0, 2'd2, 0, 6'b101001};
    vecs[17] = '{8'h25, 4'd5, 1'b0, 2'd2, 0, 6'b001011};
    vecs[18] = '{8'h26, 4'd5, 1'b0, 2'd3, 0, 6'b000000};
    vecs[19] = '{8'h13, 4'd3, 1'b1, 2'd0, 0, 6'b111001};

    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; mem_req_ready = 1'b0;
    mem_fill_done = 1'b0; flush = 1'b0;
    #2;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_outputs", {25'd0, resp_valid, resp_hit, resp_way, mem_req_valid, mem_req_way, flush_busy},
        32'd0);
    chk("rst_mem_addr", {20'd0, mem_req_addr}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) do_req(vecs[i]);

    // Flush with a simultaneous request: flush wins, request is not accepted.
    req_valid = 1'b1;
    req_addr  = {8'h12, 4'd3};
    flush     = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    req_valid = 1'b0;
    begin
      int n;
      n = 0;
      while (flush_busy === 1'b1 && n < 40) begin
        chk("flush_req_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        n++;
      end
      chk("flush_cycles", n, 32'd16);
    end
    chk("flush_lru3", {26'd0, dut.lru_q[3]}, 32'd0);
    chk("flush_lru5", {26'd0, dut.lru_q[5]}, 32'd0);
    do_req('{8'h12, 4'd3, 1'b0, 2'd0, 0, 6'b111000});
    do_req('{8'h24, 4'd5, 1'b0, 2'd0, 0, 6'b111000});

    // Reset while waiting for the fill: no response may follow.
    req_valid = 1'b1;
    req_addr  = {8'h40, 4'd7};
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("rstfill_memreq", {31'd0, mem_req_valid}, 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rstfill_memreq_drop", {31'd0, mem_req_valid}, 32'd0);
    chk("rstfill_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    mem_fill_done = 1'b1;
    @(negedge clk);
    mem_fill_done = 1'b0;
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("rstfill_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    do_req('{8'h12, 4'd3, 1'b0, 2'd0, 0, 6'b111000});
    do_req('{8'h40, 4'd7, 1'b0, 2'd0, 0, 6'b111000});

    repeat (2) @(negedge clk);
    chk("scoreboard_drain", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lru_cache_ctrl.md
Name: lru_cache_ctrl

Overview:
- Lookup/replacement controller for a 4-way set-associative cache.
- Holds a per-set tag array, valid bits and a 6-bit pairwise LRU state.
- Accepts one lookup at a time and resolves it as a hit or a miss. On a miss it picks a victim way, sequences the line fill through a memory handshake, and updates the LRU state.
- Sits between the CPU-side request port and the memory/fill interface; the data RAM is external and indexed by {set, way}.

Parameters:
- SET_BITS, 4, log2 of the number of sets (16 sets by default).
- TAG_BITS, 8, tag width. Address width ADDR_W = TAG_BITS+SET_BITS; the address is {tag, set}.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  lookup request valid.
- req_ready  out  1  controller can accept a request; high only in IDLE.
- req_addr  in  ADDR_W  lookup address.
- resp_valid  out  1  one-cycle response strobe.
- resp_hit  out  1  1 = hit, 0 = miss that has now been filled; valid with resp_valid.
- resp_way  out  2  way holding the line; valid with resp_valid.
- mem_req_valid  out  1  fill request valid.
- mem_req_ready  in  1  memory accepts the fill request.
- mem_req_addr  out  ADDR_W  line address to fetch.
- mem_req_way  out  2  destination way for the fill.
- mem_fill_done  in  1  one-cycle pulse: the fill data has been written.
- flush  in  1  invalidate-all request; sampled in IDLE only.
- flush_busy  out  1  high while a flush sweep is in progress.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE; all valid bits = 0; all LRU = 6'b000000; tags = 0.
  - resp_valid, resp_hit, resp_way, mem_req_valid, mem_req_addr, mem_req_way and flush_busy = 0; req_ready = 1.
  - Reset in any state aborts the operation: mem_req_valid drops at once and no response is issued.
- LRU encoding, 6 bits [5:0]:
  - MRU update for way 0: OR 6'b111000.
  - MRU update for way 1: AND 6'b011111, then OR 6'b000110.
  - MRU update for way 2: AND 6'b101011, then OR 6'b000001.
  - MRU update for way 3: AND 6'b110100.
  - LRU decode, first match wins: [5:3]==000 gives way 0; [5]=1 and [2:1]==00 gives way 1; [4]=1, [2]=1 and [0]=0 gives way 2; [3]=1 and [1:0]==11 gives way 3; no match gives way 0.
- IDLE:
  - req_ready = 1.
  - flush = 1 takes priority over req_valid: go to FLUSH, set flush_busy, and do not accept the request.
  - Otherwise req_valid = 1 latches req_addr and goes to LOOKUP (this is the acceptance edge).
- LOOKUP (1 cycle): compare the latched tag against all valid ways of the set.
  - Hit: LRU[set] gets the MRU update for the hit way at the exit edge; go to RESP with hit=1, way=hit way.
  - Miss: victim = lowest-index invalid way, otherwise the LRU decode of LRU[set]; latch the victim; go to FILL_REQ.
  - Multiple matching valid ways is illegal; if it occurs, the lowest-index match wins.
- FILL_REQ:
  - mem_req_valid = 1; mem_req_addr and mem_req_way are held stable until the edge where mem_req_ready = 1, then go to FILL_WAIT.
  - mem_fill_done in this state is ignored.
- FILL_WAIT:
  - mem_req_valid = 0.
  - On mem_fill_done: tag[set][victim] = tag, valid = 1, LRU[set] gets the MRU update for the victim. Go to RESP with hit=0, way=victim.
- RESP: resp_valid = 1 for exactly one cycle, then go to IDLE.
- Timing:
  - Hit: resp_valid is high in the second cycle after the acceptance edge; throughput is one hit per 3 cycles.
  - Miss: resp_valid is high the cycle after the mem_fill_done edge.
- FLUSH:
  - One set per cycle, sets 0 to 2^SET_BITS-1: clear its valid bits and set LRU = 0.
  - flush_busy stays high for 2^SET_BITS cycles; after the last set, go to IDLE.
  - req_ready = 0 throughout; flush has no effect outside IDLE.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.

Test Plan:
1. After reset, request {tag 0x12, set 3} -> miss, mem_req_way=0, mem_req_addr=0x123. Pulse mem_fill_done -> resp_valid with hit=0, way=0; LRU[3]=6'b111000.
2. Continue with misses to set 3, tags 0x13, 0x14, 0x15 -> fills go to ways 1, 2, 3. LRU[3] steps 6'b011110, 6'b001011, 6'b000000. A further miss, tag 0x16 -> mem_req_way=0.
3. After scenario 2 without tag 0x16, request tag 0x12 -> hit, way 0, resp_valid 2 cycles after acceptance, no mem_req_valid, LRU[3]=6'b111000. Then miss tag 0x16 -> victim way 1.
4. Hold mem_req_ready=0 for 5 cycles in FILL_REQ -> mem_req_valid, mem_req_addr and mem_req_way stay stable; req_ready=0; mem_fill_done pulsed during FILL_REQ is ignored.
5. With set 3 full, pulse flush in IDLE -> flush_busy high for exactly 16 cycles. Afterwards tag 0x12/set 3 misses with victim way 0.
6. Assert reset_n=0 mid-FILL_WAIT -> mem_req_valid=0 and no resp_valid. After release, a previously filled address misses.
